seven_segment_monitor: RTL and testbench
========================================

Name: seven_segment_monitor

Overview:
Receive-side counterpart of the seven-segment seconds counter. It samples a seven-segment bus, filters glitches and decodes each stable pattern back to a BCD digit. It checks that digits step 0..9 with wrap and that the interval between steps equals the counter period. It serves as an on-chip loopback checker or as a front end for reading an external display.

Parameters:
MAX_COUNT, 10_000_000, counter terminal value; expected step period = MAX_COUNT+1 cycles
STABLE_CYCLES, 4, consecutive identical samples needed to accept a pattern (range 1..255)
PERIOD_TOL, 16, allowed absolute deviation of a measured period, in cycles
PERIOD_W, 24, width of the period counter; must hold MAX_COUNT+1+PERIOD_TOL

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
seg_in  input  7  segments {g,f,e,d,c,b,a}, active high, asynchronous to clk
digit  output  4  last accepted valid digit
digit_valid  output  1  high while the accepted pattern is a legal digit
new_digit  output  1  one-cycle pulse when a different valid digit is accepted
period  output  PERIOD_W  cycles between the last two accepted digit changes
period_valid  output  1  one-cycle pulse with period update
pattern_err  output  1  one-cycle pulse when an illegal pattern is accepted
step_err  output  1  one-cycle pulse when a change is not (prev+1) mod 10
period_err  output  1  one-cycle pulse when |period-(MAX_COUNT+1)| > PERIOD_TOL
err_count  output  8  saturating count of all error pulses

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0; synchronizer, filter and period counter cleared; no previous digit is held.
- Input path: 2-flop synchronizer on seg_in, then a stability filter.
  - The filter compares each sample with the previous one. A mismatch reloads stab_cnt to 1; a match increments it, saturating.
  - When stab_cnt reaches STABLE_CYCLES and the sample differs from the accepted pattern, it becomes the accepted pattern (accept event).
  - Latency from a seg_in change to the accept event: 2 + STABLE_CYCLES cycles.
- Legal patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- Accept of an illegal pattern: pattern_err pulse, digit_valid<=0, digit holds its value, previous-digit reference is kept.
- Accept of a legal pattern D:
  - digit<=D and digit_valid<=1.
  - If a previous digit P exists and D != P: new_digit pulse. If D != (P==9 ? 0 : P+1), step_err pulse.
  - The first legal digit after reset raises no new_digit and no step_err; it only starts period timing.
  - The legal digit returning after an illegal glitch is compared against P. If D == P, no pulse.
- Period counter:
  - Runs continuously after the first legal accept and saturates at all-ones.
  - On each new_digit: period<=count+1, period_valid pulse, count reloads to 0.
  - The period check is made in the same cycle; a saturated count always raises period_err.
  - No period is reported for the first change after reset.
- Pulse timing: all pulses occur in the cycle after the accept event and are registered.
- err_count increments by the number of error pulses in that cycle (0..3) and saturates at 255.

Decomposition:
- Package seg7_pkg:
  - the ten segment-pattern constants;
  - the segment bit-order definition;
  - function pattern_to_digit returning {legal, digit}.
- One sub-module, seg7_decode: combinational pattern-to-digit decoder using the package function. It mirrors the existing seg7 encoder.
- Synchronizer, filter, checker and period counter stay in the top module.

Test Plan:
- Use MAX_COUNT=20 and STABLE_CYCLES=4 throughout.
- Reset/first digit: hold seg_in=0x3F after reset -> digit=0 and digit_valid=1 after 6 cycles; no new_digit, step_err or period_valid.
- Normal stepping: drive 0x3F,0x06,...,0x6F then 0x3F, each held 21 cycles -> new_digit on each change, wrap 9->0 accepted, every period=21, no errors, err_count=0.
- Glitch rejection: during digit 3, drive a 3-cycle pulse of 0x7F -> no accept, digit stays 3, no pulses.
- Illegal then skip: drive 0x49 held 10 cycles -> pattern_err and digit_valid=0; then 0x66 (4) after digit 2 -> step_err, err_count=2.
- Period error: step 5->6 after 40 cycles -> period=40, period_err. Step after exactly 21±16 -> no error.
- Async reset mid-run: assert rst_n low between clock edges -> outputs 0 immediately. After release, the next digit is treated as first (no step_err).

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants and decode helper
package seg7_pkg;

    localparam int SEG_W = 7;

    // Bit position of each segment on the bus {g,f,e,d,c,b,a}
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    typedef struct packed {
        logic       legal;
        logic [3:0] digit;
    } seg_decode_t;

    // Inverse of the seg7 encoder; anything off-table is reported illegal with digit 0
    function automatic seg_decode_t pattern_to_digit(input logic [SEG_W-1:0] pat);
        seg_decode_t r;
        r.legal = 1'b1;
        r.digit = 4'd0;
        case (pat)
            SEG_0:   r.digit = 4'd0;
            SEG_1:   r.digit = 4'd1;
            SEG_2:   r.digit = 4'd2;
            SEG_3:   r.digit = 4'd3;
            SEG_4:   r.digit = 4'd4;
            SEG_5:   r.digit = 4'd5;
            SEG_6:   r.digit = 4'd6;
            SEG_7:   r.digit = 4'd7;
            SEG_8:   r.digit = 4'd8;
            SEG_9:   r.digit = 4'd9;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational seven-segment to BCD decoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             legal,
    output logic [3:0]       digit
);

    seg_decode_t dec;

    // Pure table lookup shared with the package so encoder and decoder cannot drift
    always_comb begin
        dec   = pattern_to_digit(pattern);
        legal = dec.legal;
        digit = dec.digit;
    end

endmodule

// File: rtl/seven_segment_monitor.sv
// rtl/seven_segment_monitor.sv - filters, decodes and checks a seven-segment seconds display
module seven_segment_monitor
    import seg7_pkg::*;
#(
    parameter int MAX_COUNT     = 10_000_000,
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_TOL    = 16,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEG_W-1:0]    seg_in,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                new_digit,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                pattern_err,
    output logic                step_err,
    output logic                period_err,
    output logic [7:0]          err_count
);

    localparam logic [PERIOD_W-1:0] CNT_MAX      = '1;
    localparam logic [PERIOD_W-1:0] PERIOD_NOM   = PERIOD_W'(MAX_COUNT + 1);
    localparam logic [PERIOD_W-1:0] PERIOD_TOL_W = PERIOD_W'(PERIOD_TOL);
    localparam logic [7:0]          STAB_TGT     = 8'(STABLE_CYCLES);

    logic                rst_meta_n, rst_int_n;
    logic [SEG_W-1:0]    seg_meta, seg_sync, seg_last, seg_acc;
    logic [7:0]          stab_cnt;
    logic                dec_legal;
    logic [3:0]          dec_digit;
    logic [3:0]          prev_digit, prev_succ;
    logic                have_prev, have_change;
    logic [PERIOD_W-1:0] count, period_meas, period_dev;
    logic                accept, pat_bad, changed, step_bad, report, period_bad;
    logic [1:0]          err_inc;
    logic [8:0]          err_sum;
    logic [7:0]          err_next;

    // Reset asserts immediately but is released on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_int_n  <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_int_n  <= rst_meta_n;
        end
    end

    // Two-flop synchronizer followed by a run-length count of identical samples
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            seg_meta <= '0;
            seg_sync <= '0;
            seg_last <= '0;
            stab_cnt <= '0;
        end else begin
            seg_meta <= seg_in;
            seg_sync <= seg_meta;
            seg_last <= seg_sync;
            if (seg_sync != seg_last)
                stab_cnt <= 8'd1;
            else if (stab_cnt != 8'hFF)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    seg7_decode u_decode (
        .pattern (seg_last),
        .legal   (dec_legal),
        .digit   (dec_digit)
    );

    // Accept decisions: a run just reached the threshold on a pattern we do not already hold
    assign accept    = (stab_cnt == STAB_TGT) && (seg_last != seg_acc);
    assign pat_bad   = accept && !dec_legal;
    assign prev_succ = (prev_digit == 4'd9) ? 4'd0 : prev_digit + 4'd1;
    assign changed   = accept && dec_legal && have_prev && (dec_digit != prev_digit);
    assign step_bad  = changed && (dec_digit != prev_succ);
    // The first change after reset has no trustworthy start point, so it is not reported
    assign report    = changed && have_change;

    // A saturated counter reports all-ones and is always out of tolerance
    assign period_meas = (count == CNT_MAX) ? CNT_MAX : count + PERIOD_W'(1);
    assign period_dev  = (period_meas > PERIOD_NOM) ? period_meas - PERIOD_NOM
                                                    : PERIOD_NOM - period_meas;
    assign period_bad  = report && ((count == CNT_MAX) || (period_dev > PERIOD_TOL_W));

    assign err_inc  = 2'(pat_bad) + 2'(step_bad) + 2'(period_bad);
    assign err_sum  = {1'b0, err_count} + {7'd0, err_inc};
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    // Registered digit tracking, sequence/period checks and error accounting
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            seg_acc      <= '0;
            digit        <= '0;
            digit_valid  <= 1'b0;
            prev_digit   <= '0;
            have_prev    <= 1'b0;
            have_change  <= 1'b0;
            count        <= '0;
            new_digit    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            pattern_err  <= 1'b0;
            step_err     <= 1'b0;
            period_err   <= 1'b0;
            err_count    <= '0;
        end else begin
            new_digit    <= changed;
            period_valid <= report;
            pattern_err  <= pat_bad;
            step_err     <= step_bad;
            period_err   <= period_bad;
            err_count    <= err_next;

            if (accept)
                seg_acc <= seg_last;
            if (pat_bad)
                digit_valid <= 1'b0;
            if (accept && dec_legal) begin
                digit       <= dec_digit;
                digit_valid <= 1'b1;
                prev_digit  <= dec_digit;
                have_prev   <= 1'b1;
            end
            if (report)
                period <= period_meas;

            if (changed) begin
                have_change <= 1'b1;
                count       <= '0;
            end else if (accept && dec_legal && !have_prev) begin
                count <= '0;
            end else if (have_prev && count != CNT_MAX) begin
                count <= count + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb/tb_seven_segment_monitor.sv - randomized check of seven_segment_monitor against a behavioural model
module tb_seven_segment_monitor;

    localparam int MAX_COUNT     = 20;
    localparam int STABLE_CYCLES = 4;
    localparam int PERIOD_TOL    = 16;
    localparam int PERIOD_W      = 8;
    localparam int NOM           = MAX_COUNT + 1;
    localparam int PMAX          = (1 << PERIOD_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [6:0]          seg_in = 7'h00;
    logic [3:0]          digit;
    logic                digit_valid, new_digit, period_valid;
    logic                pattern_err, step_err, period_err;
    logic [PERIOD_W-1:0] period;
    logic [7:0]          err_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seven_segment_monitor #(
        .MAX_COUNT     (MAX_COUNT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .PERIOD_TOL    (PERIOD_TOL),
        .PERIOD_W      (PERIOD_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .new_digit    (new_digit),
        .period       (period),
        .period_valid (period_valid),
        .pattern_err  (pattern_err),
        .step_err     (step_err),
        .period_err   (period_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Model state: raw sample history since reset, plus what the display means
    int h[$];
    int hold_off, acc, have_prev, prev, have_change, cyc, last_change;
    int m_digit, m_valid, m_new, m_pv, m_pat, m_step, m_perr, m_period, m_err;

    int pv_log[$];
    int pe_log[$];
    int n_new_seen = 0;
    int n_pat_seen = 0;
    int n_step_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int lookup(input int p);
        for (int i = 0; i < 10; i++)
            if (int'(pat_tab[i]) == p) return i;
        return -1;
    endfunction

    // True when the sample at index c closes a run of exactly STABLE_CYCLES equal samples
    function automatic bit stable_exact(input int c);
        if (c - STABLE_CYCLES + 1 < 0) return 1'b0;
        for (int i = c - STABLE_CYCLES + 1; i < c; i++)
            if (h[i] != h[c]) return 1'b0;
        if (c - STABLE_CYCLES >= 0 && h[c - STABLE_CYCLES] == h[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        h.delete();
        h.push_back(0);
        h.push_back(0);
        hold_off = 2;
        acc = 0; have_prev = 0; prev = 0; have_change = 0; cyc = 0; last_change = 0;
        m_digit = 0; m_valid = 0; m_new = 0; m_pv = 0; m_pat = 0; m_step = 0;
        m_perr = 0; m_period = 0; m_err = 0;
    endtask

    // One clock of the reference: a pattern seen after the sync delay for exactly
    // STABLE_CYCLES samples is accepted, and its meaning is reported one clock later
    task automatic model_step(input int x);
        int c, d, diff;
        h.push_back(x);
        cyc++;
        m_new = 0; m_pv = 0; m_pat = 0; m_step = 0; m_perr = 0;
        c = h.size() - 4;
        if (c >= 0 && stable_exact(c) && h[c] != acc) begin
            acc = h[c];
            d = lookup(acc);
            if (d < 0) begin
                m_pat = 1;
                m_valid = 0;
            end else begin
                m_digit = d;
                m_valid = 1;
                if (have_prev != 0 && d != prev) begin
                    m_new = 1;
                    if (d != (prev + 1) % 10) m_step = 1;
                    if (have_change != 0) begin
                        diff = cyc - last_change;
                        m_pv = 1;
                        m_period = (diff > PMAX) ? PMAX : diff;
                        m_perr = (diff > PMAX || iabs(m_period - NOM) > PERIOD_TOL) ? 1 : 0;
                    end
                    have_change = 1;
                    last_change = cyc;
                end
                have_prev = 1;
                prev = d;
            end
        end
        m_err = m_err + m_pat + m_step + m_perr;
        if (m_err > 255) m_err = 255;
    endtask

    // Reference follows the same reset and clock the DUT sees
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else if (hold_off > 0) hold_off--;
        else model_step(int'(seg_in));
    end

    // Every-cycle comparison, half a clock away from the active edge
    always @(negedge clk) begin
        chk("digit",        int'(digit),        m_digit);
        chk("digit_valid",  int'(digit_valid),  m_valid);
        chk("new_digit",    int'(new_digit),    m_new);
        chk("period_valid", int'(period_valid), m_pv);
        chk("pattern_err",  int'(pattern_err),  m_pat);
        chk("step_err",     int'(step_err),     m_step);
        chk("period_err",   int'(period_err),   m_perr);
        chk("err_count",    int'(err_count),    m_err);
        if (m_pv != 0) chk("period", int'(period), m_period);
        if (period_valid) begin
            pv_log.push_back(int'(period));
            pe_log.push_back(int'(period_err));
        end
        if (new_digit)   n_new_seen++;
        if (pattern_err) n_pat_seen++;
        if (step_err)    n_step_seen++;
    end

    task automatic drive(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digit"},     int'(digit),        0);
        chk({tag, "_valid"},     int'(digit_valid),  0);
        chk({tag, "_new"},       int'(new_digit),    0);
        chk({tag, "_period"},    int'(period),       0);
        chk({tag, "_pv"},        int'(period_valid), 0);
        chk({tag, "_errs"},      int'({pattern_err, step_err, period_err}), 0);
        chk({tag, "_err_count"}, int'(err_count),    0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

    int cur, r, nn, base_new, base_pv;
    logic [6:0] p;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        seg_in = 7'h3F;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // First digit after reset: accepted silently
        drive(pat_tab[0], 21);
        chk("first_digit", int'(digit), 0);
        chk("first_valid", int'(digit_valid), 1);
        chk("first_no_new", n_new_seen, 0);
        chk("first_no_pv", pv_log.size(), 0);

        // Normal stepping 1..9 then wrap to 0, with a short 0x7F glitch during 3
        for (int d = 1; d <= 10; d++) begin
            if (d == 3) begin
                drive(pat_tab[3], 9);
                drive(7'h7F, 3);
                drive(pat_tab[3], 9);
                chk("glitch_digit", int'(digit), 3);
            end else begin
                drive(pat_tab[d % 10], 21);
            end
        end
        chk("step_new_count", n_new_seen, 10);
        chk("step_pv_count", pv_log.size(), 9);
        chk("step_period", pv_log[8], 21);
        chk("model_period", m_period, 21);
        chk("step_err_count", int'(err_count), 0);
        chk("wrap_digit", int'(digit), 0);

        // Illegal pattern then a skipped digit (2 -> 4)
        drive(pat_tab[1], 21);
        drive(pat_tab[2], 21);
        drive(7'h49, 10);
        chk("illegal_valid", int'(digit_valid), 0);
        chk("illegal_hold", int'(digit), 2);
        drive(pat_tab[4], 21);
        chk("skip_err_count", int'(err_count), 2);
        chk("model_err", m_err, 2);
        chk("skip_pat_seen", n_pat_seen, 1);
        chk("skip_step_seen", n_step_seen, 1);
        chk("skip_period", pv_log[11], 31);

        // Period tolerance boundaries and counter saturation
        drive(pat_tab[5], 40);
        drive(pat_tab[6], 37);
        drive(pat_tab[7], 5);
        drive(pat_tab[8], 38);
        drive(pat_tab[9], 300);
        drive(pat_tab[0], 21);
        chk("pv_total", pv_log.size(), 18);
        chk("p40", pv_log[13], 40);
        chk("p40_err", pe_log[13], 1);
        chk("p37", pv_log[14], 37);
        chk("p37_err", pe_log[14], 0);
        chk("p5", pv_log[15], 5);
        chk("p5_err", pe_log[15], 0);
        chk("p38_err", pe_log[16], 1);
        chk("psat", pv_log[17], PMAX);
        chk("psat_err", pe_log[17], 1);
        chk("period_err_count", int'(err_count), 5);

        // Asynchronous reset between clock edges
        #3 rst_n = 1'b0;
        #1 chk_zero("async");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        base_new = n_new_seen;
        base_pv  = pv_log.size();
        drive(pat_tab[1], 25);
        chk("post_first_digit", int'(digit), 1);
        chk("post_first_err", int'(err_count), 0);
        chk("post_first_new", n_new_seen - base_new, 0);
        drive(pat_tab[5], 21);
        chk("post_step_err", int'(err_count), 1);
        chk("post_no_period", int'(pv_log.size()) - base_pv, 0);

        // Randomized traffic: mostly in-sequence steps, some jumps, junk and short glitches
        cur = 5;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                cur = (cur + 1) % 10;
                p = pat_tab[cur];
            end else if (r < 8) begin
                cur = $urandom_range(0, 9);
                p = pat_tab[cur];
            end else begin
                p = 7'($urandom_range(0, 127));
            end
            nn = $urandom_range(1, 45);
            drive(p, nn);
        end
        drive(pat_tab[(cur + 1) % 10], 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
